// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, long-latency
// results queue in a small FIFO and drain into idle slots, with a forced drain on starvation.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_reg,
  input  logic [31:0] pipe_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_reg,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic [4:0]  query_reg,
  output logic        pend_hit,
  output logic        stall_req,
  output logic [4:0]  wb_write_reg,
  output logic [31:0] wb_write_data,
  output logic        wb_write_valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  typedef enum logic {ST_NORMAL = 1'b0, ST_STARVED = 1'b1} state_e;

  state_e          state_q;
  logic [SW-1:0]   starve_cnt_q;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [4:0]      fifo_reg_q  [DEPTH];
  logic [31:0]     fifo_data_q [DEPTH];
  logic [4:0]      wb_reg_q;
  logic [31:0]     wb_data_q;
  logic            wb_valid_q;

  logic empty;
  logic pipe_live;
  logic pop;
  logic push;
  logic bypass;
  logic hit;

  // Long-latency handshake: a result transfers on a cycle where lu_valid && lu_ready.
  // lu_ready depends only on the registered count, so it never combinationally
  // follows lu_valid. x0 results transfer too but are simply discarded.
  assign lu_ready  = (count_q < CW'(DEPTH));
  assign stall_req = (state_q == ST_STARVED);
  assign empty     = (count_q == '0);
  assign pipe_live = pipe_valid && (pipe_reg != 5'd0) && !stall_req;
  assign pop       = !pipe_live && !empty;
  assign bypass    = !pipe_live && empty && lu_valid && (lu_reg != 5'd0);
  assign push      = lu_valid && lu_ready && (lu_reg != 5'd0) && (pipe_live || !empty);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (fifo_reg_q[rd_ptr_q + AW'(i)] == query_reg)) begin
        hit = 1'b1;
      end
    end
    pend_hit = hit && (query_reg != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg_q[wr_ptr_q]  <= lu_reg;
      fifo_data_q[wr_ptr_q] <= lu_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_NORMAL;
      starve_cnt_q <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      wb_reg_q     <= 5'd0;
      wb_data_q    <= 32'd0;
      wb_valid_q   <= 1'b0;
    end else begin
      count_q <= count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);

      if (pipe_live) begin
        wb_reg_q   <= pipe_reg;
        wb_data_q  <= pipe_data;
        wb_valid_q <= 1'b1;
      end else if (pop) begin
        wb_reg_q   <= fifo_reg_q[rd_ptr_q];
        wb_data_q  <= fifo_data_q[rd_ptr_q];
        wb_valid_q <= 1'b1;
      end else if (bypass) begin
        wb_reg_q   <= lu_reg;
        wb_data_q  <= lu_data;
        wb_valid_q <= 1'b1;
      end else begin
        wb_valid_q <= 1'b0;
      end

      // The freeze is entered on the cycle the counter would reach LIMIT-1, so a
      // queued head waits at most STARVE_LIMIT+1 cycles from push to writeback.
      case (state_q)
        ST_NORMAL: begin
          if (empty || pop) begin
            starve_cnt_q <= '0;
          end else if (int'(starve_cnt_q) + 1 >= STARVE_LIMIT - 1) begin
            starve_cnt_q <= '0;
            state_q      <= ST_STARVED;
          end else begin
            starve_cnt_q <= starve_cnt_q + SW'(1);
          end
        end
        ST_STARVED: begin
          starve_cnt_q <= '0;
          state_q      <= ST_NORMAL;
        end
        default: state_q <= ST_NORMAL;
      endcase
    end
  end

  assign wb_write_reg   = wb_reg_q;
  assign wb_write_data  = wb_data_q;
  assign wb_write_valid = wb_valid_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4): bypass, x0 drops,
// starvation freeze timing, x0 pipeline slot, push/pop overlap and mid-stream reset.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pipe_valid;
  logic [4:0]  pipe_reg;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  query_reg;
  logic        pend_hit;
  logic        stall_req;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        wb_write_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pipe_valid    (pipe_valid),
    .pipe_reg      (pipe_reg),
    .pipe_data     (pipe_data),
    .lu_valid      (lu_valid),
    .lu_reg        (lu_reg),
    .lu_data       (lu_data),
    .lu_ready      (lu_ready),
    .query_reg     (query_reg),
    .pend_hit      (pend_hit),
    .stall_req     (stall_req),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data),
    .wb_write_valid(wb_write_valid)
  );

  // Inputs change at the falling edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    pipe_valid = 1'b0;
    pipe_reg   = 5'd0;
    pipe_data  = 32'd0;
    lu_valid   = 1'b0;
    lu_reg     = 5'd0;
    lu_data    = 32'd0;
    query_reg  = 5'd0;
  endtask

  task automatic drive_pipe(input logic [4:0] r, input logic [31:0] d);
    pipe_valid = 1'b1;
    pipe_reg   = r;
    pipe_data  = d;
  endtask

  task automatic drive_lu(input logic [4:0] r, input logic [31:0] d);
    lu_valid = 1'b1;
    lu_reg   = r;
    lu_data  = d;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    drive_idle();
    #2 reset_n = 1'b0;
    tick();
    tick();
    checks++; if (wb_write_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_write_valid); end
    checks++; if (wb_write_reg !== 5'd0) begin errors++; $display("FAIL reset_wb_reg got=%0d exp=0", wb_write_reg); end
    checks++; if (wb_write_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data got=%h exp=0", wb_write_data); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL reset_lu_ready got=%0b exp=1", lu_ready); end
    reset_n = 1'b1;
    tick();
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL post_reset_lu_ready got=%0b exp=1", lu_ready); end
    checks++; if (pend_hit !== 1'b0) begin errors++; $display("FAIL post_reset_pend_hit got=%0b exp=0", pend_hit); end
  endtask

  task automatic test_bypass();
    drive_idle();
    query_reg = 5'd5;
    drive_lu(5'd5, 32'h0000_00AA);
    #1;
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL bypass_lu_ready got=%0b exp=1", lu_ready); end
    tick();
    drive_idle();
    query_reg = 5'd5;
    #1;
    checks++; if (wb_write_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got=%0b exp=1", wb_write_valid); end
    checks++; if (wb_write_reg !== 5'd5) begin errors++; $display("FAIL bypass_reg got=%0d exp=5", wb_write_reg); end
    checks++; if (wb_write_data !== 32'h0000_00AA) begin errors++; $display("FAIL bypass_data got=%h exp=000000aa", wb_write_data); end
    checks++; if (pend_hit !== 1'b0) begin errors++; $display("FAIL bypass_pend_hit got=%0b exp=0", pend_hit); end
    tick();
    checks++; if (wb_write_valid !== 1'b0) begin errors++; $display("FAIL bypass_no_queue got=%0b exp=0", wb_write_valid); end
  endtask

  task automatic test_x0_lu();
    drive_idle();
    drive_lu(5'd0, 32'hFFFF_FFFF);
    #1;
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL x0_lu_ready got=%0b exp=1", lu_ready); end
    tick();
    drive_idle();
    #1;
    checks++; if (wb_write_valid !== 1'b0) begin errors++; $display("FAIL x0_lu_no_write got=%0b exp=0", wb_write_valid); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL x0_lu_ready_after got=%0b exp=1", lu_ready); end
    tick();
    checks++; if (wb_write_valid !== 1'b0) begin errors++; $display("FAIL x0_lu_not_queued got=%0b exp=0", wb_write_valid); end
  endtask

  // Pipeline saturated with reg 3; regs 7 and 9 pushed in cycles 0 and 1.
  // Freeze cycles are 4 and 8; reg 7 lands in cycle 5, reg 9 in cycle 9.
  task automatic test_starvation();
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic        exp_stall;
    logic        exp_ready;
    logic        exp_hit;
    for (int k = 0; k < 10; k++) begin
      drive_idle();
      drive_pipe(5'd3, 32'h11);
      if (k == 0) drive_lu(5'd7, 32'h77);
      if (k == 1) drive_lu(5'd9, 32'h99);
      tick();
      drive_idle();
      query_reg = (k + 1 <= 4) ? 5'd7 : 5'd9;
      #1;
      exp_stall = (k + 1 == 4) || (k + 1 == 8);
      exp_reg   = (k == 4) ? 5'd7 : (k == 8) ? 5'd9 : 5'd3;
      exp_data  = (k == 4) ? 32'h77 : (k == 8) ? 32'h99 : 32'h11;
      exp_ready = !((k + 1 >= 2) && (k + 1 <= 4));
      exp_hit   = (k + 1 <= 7);
      checks++; if (stall_req !== exp_stall) begin errors++; $display("FAIL starve_stall cyc=%0d got=%0b exp=%0b", k + 1, stall_req, exp_stall); end
      checks++; if (wb_write_valid !== 1'b1) begin errors++; $display("FAIL starve_valid cyc=%0d got=%0b exp=1", k + 1, wb_write_valid); end
      checks++; if (wb_write_reg !== exp_reg) begin errors++; $display("FAIL starve_reg cyc=%0d got=%0d exp=%0d", k + 1, wb_write_reg, exp_reg); end
      checks++; if (wb_write_data !== exp_data) begin errors++; $display("FAIL starve_data cyc=%0d got=%h exp=%h", k + 1, wb_write_data, exp_data); end
      checks++; if (lu_ready !== exp_ready) begin errors++; $display("FAIL starve_lu_ready cyc=%0d got=%0b exp=%0b", k + 1, lu_ready, exp_ready); end
      if ((k + 1 != 4) && (k + 1 != 8)) begin
        checks++; if (pend_hit !== exp_hit) begin errors++; $display("FAIL starve_pend_hit cyc=%0d q=%0d got=%0b exp=%0b", k + 1, query_reg, pend_hit, exp_hit); end
      end
    end
  endtask

  task automatic test_x0_pipe();
    drive_idle();
    drive_pipe(5'd3, 32'h11);
    drive_lu(5'd12, 32'h0000_C0C0);
    tick();
    drive_idle();
    query_reg = 5'd12;
    #1;
    checks++; if (pend_hit !== 1'b1) begin errors++; $display("FAIL x0pipe_queued_hit got=%0b exp=1", pend_hit); end
    checks++; if (wb_write_reg !== 5'd3) begin errors++; $display("FAIL x0pipe_pipe_reg got=%0d exp=3", wb_write_reg); end
    drive_pipe(5'd0, 32'hDEAD_BEEF);
    tick();
    drive_idle();
    query_reg = 5'd12;
    #1;
    checks++; if (wb_write_valid !== 1'b1) begin errors++; $display("FAIL x0pipe_valid got=%0b exp=1", wb_write_valid); end
    checks++; if (wb_write_reg !== 5'd12) begin errors++; $display("FAIL x0pipe_reg got=%0d exp=12", wb_write_reg); end
    checks++; if (wb_write_data !== 32'h0000_C0C0) begin errors++; $display("FAIL x0pipe_data got=%h exp=0000c0c0", wb_write_data); end
    checks++; if (pend_hit !== 1'b0) begin errors++; $display("FAIL x0pipe_drained_hit got=%0b exp=0", pend_hit); end
    tick();
    checks++; if (wb_write_valid !== 1'b0) begin errors++; $display("FAIL x0pipe_idle got=%0b exp=0", wb_write_valid); end
  endtask

  task automatic test_back_to_back();
    drive_idle();
    drive_pipe(5'd3, 32'h11);
    drive_lu(5'd13, 32'h1313);
    tick();
    drive_idle();
    drive_lu(5'd14, 32'h1414);
    tick();
    drive_idle();
    query_reg = 5'd14;
    #1;
    checks++; if (wb_write_reg !== 5'd13) begin errors++; $display("FAIL b2b_first_reg got=%0d exp=13", wb_write_reg); end
    checks++; if (wb_write_data !== 32'h1313) begin errors++; $display("FAIL b2b_first_data got=%h exp=00001313", wb_write_data); end
    checks++; if (pend_hit !== 1'b1) begin errors++; $display("FAIL b2b_hit14 got=%0b exp=1", pend_hit); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL b2b_count1_ready got=%0b exp=1", lu_ready); end
    query_reg = 5'd13;
    #1;
    checks++; if (pend_hit !== 1'b0) begin errors++; $display("FAIL b2b_hit13 got=%0b exp=0", pend_hit); end
    tick();
    checks++; if (wb_write_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got=%0b exp=1", wb_write_valid); end
    checks++; if (wb_write_reg !== 5'd14) begin errors++; $display("FAIL b2b_second_reg got=%0d exp=14", wb_write_reg); end
    checks++; if (wb_write_data !== 32'h1414) begin errors++; $display("FAIL b2b_second_data got=%h exp=00001414", wb_write_data); end
    tick();
    checks++; if (wb_write_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%0b exp=0", wb_write_valid); end
  endtask

  task automatic test_reset_mid_stream();
    drive_idle();
    drive_pipe(5'd3, 32'h11);
    drive_lu(5'd20, 32'h2020);
    tick();
    drive_lu(5'd21, 32'h2121);
    tick();
    lu_valid  = 1'b0;
    query_reg = 5'd20;
    #1;
    checks++; if (wb_write_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%0b exp=1", wb_write_valid); end
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL rst_pre_full got=%0b exp=0", lu_ready); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (wb_write_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%0b exp=0", wb_write_valid); end
    checks++; if (wb_write_reg !== 5'd0) begin errors++; $display("FAIL rst_async_reg got=%0d exp=0", wb_write_reg); end
    checks++; if (wb_write_data !== 32'd0) begin errors++; $display("FAIL rst_async_data got=%h exp=0", wb_write_data); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_async_stall got=%0b exp=0", stall_req); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready got=%0b exp=1", lu_ready); end
    checks++; if (pend_hit !== 1'b0) begin errors++; $display("FAIL rst_async_hit got=%0b exp=0", pend_hit); end
    tick();
    drive_idle();
    reset_n = 1'b1;
    tick();
    query_reg = 5'd21;
    #1;
    checks++; if (wb_write_valid !== 1'b0) begin errors++; $display("FAIL rst_after_valid got=%0b exp=0", wb_write_valid); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL rst_after_ready got=%0b exp=1", lu_ready); end
    checks++; if (pend_hit !== 1'b0) begin errors++; $display("FAIL rst_after_hit got=%0b exp=0", pend_hit); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_x0_lu();
    test_starvation();
    test_x0_pipe();
    test_back_to_back();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
